// File: rtl/memory_read_arbiter_pkg.sv
// Shared types for the cache-to-AXI read arbiter: requester identity and read-ID path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package memory_read_arbiter_pkg;

    localparam int MRA_ID_WIDTH = 2;

    typedef enum logic {
        MRRS_ICACHE = 1'b0,
        MRRS_DCACHE = 1'b1
    } MemReadReqSource;

    typedef logic [MRA_ID_WIDTH-1:0] MemReadIdPath;

    // Round-robin partner of a requester.
    function automatic MemReadReqSource other_source(input MemReadReqSource s);
        return (s == MRRS_ICACHE) ? MRRS_DCACHE : MRRS_ICACHE;
    endfunction

endpackage

// File: rtl/memory_read_id_allocator.sv
// Tracks which AXI read IDs are outstanding and which cache owns each one.
// Latency: allocate/free take effect at the next edge; lookup and lowest-free are combinational.
// Backpressure: none internally; anyFree tells the arbiter when to stall requesters.
module memory_read_id_allocator
    import memory_read_arbiter_pkg::*;
#(
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                allocValid,
    input  MemReadReqSource     allocOwner,
    output logic [ID_WIDTH-1:0] allocId,
    input  logic                freeValid,
    input  logic [ID_WIDTH-1:0] freeId,
    input  logic [ID_WIDTH-1:0] lookupId,
    output logic                lookupBusy,
    output MemReadReqSource     lookupOwner,
    output logic                anyFree,
    output logic                anyBusy
);

    localparam int ID_NUM = 2 ** ID_WIDTH;

    logic [ID_NUM-1:0]                  busyVec;
    MemReadReqSource [ID_NUM-1:0]       owner;

    // Lowest-numbered free ID; scanning downward lets the smallest index win.
    always_comb begin
        allocId = '0;
        for (int i = ID_NUM - 1; i >= 0; i--) begin
            if (!busyVec[i]) allocId = ID_WIDTH'(i);
        end
    end

    assign anyFree     = ~&busyVec;
    assign anyBusy     = |busyVec;
    assign lookupBusy  = busyVec[lookupId];
    assign lookupOwner = owner[lookupId];

    // Outstanding table; a freed ID is the one just returned, never the one being allocated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busyVec <= '0;
            for (int i = 0; i < ID_NUM; i++) owner[i] <= MRRS_ICACHE;
        end else begin
            for (int i = 0; i < ID_NUM; i++) begin
                if (freeValid && freeId == ID_WIDTH'(i)) busyVec[i] <= 1'b0;
                if (allocValid && allocId == ID_WIDTH'(i)) begin
                    busyVec[i] <= 1'b1;
                    owner[i]   <= allocOwner;
                end
            end
        end
    end

endmodule

// File: rtl/memory_read_arbiter.sv
// Round-robin I/D-cache read arbiter onto one AXI4 AR/R pair with read-ID allocation and R routing.
// Latency: accept -> arValid one cycle; R beats routed to the owning cache combinationally.
// Backpressure: requests stall while the AR register is held by !arReady or all IDs are outstanding.
module memory_read_arbiter
    import memory_read_arbiter_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icReqValid,
    input  logic [ADDR_WIDTH-1:0] icReqAddr,
    output logic                  icReqReady,
    input  logic                  dcReqValid,
    input  logic [ADDR_WIDTH-1:0] dcReqAddr,
    output logic                  dcReqReady,
    output logic                  arValid,
    input  logic                  arReady,
    output logic [ID_WIDTH-1:0]   arId,
    output logic [ADDR_WIDTH-1:0] arAddr,
    input  logic                  rValid,
    output logic                  rReady,
    input  logic [ID_WIDTH-1:0]   rId,
    input  logic [DATA_WIDTH-1:0] rData,
    input  logic                  rLast,
    output logic                  icRespValid,
    output logic [DATA_WIDTH-1:0] icRespData,
    output logic                  icRespLast,
    output logic                  dcRespValid,
    output logic [DATA_WIDTH-1:0] dcRespData,
    output logic                  dcRespLast,
    output logic                  busy,
    output logic                  protocolError
);

    MemReadReqSource       rrPtr;
    MemReadReqSource       acceptSrc;
    MemReadReqSource       lookupOwner;
    logic                  slotFree;
    logic                  grantIc;
    logic                  grantDc;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] acceptAddr;
    logic [ID_WIDTH-1:0]   allocId;
    logic                  lookupBusy;
    logic                  anyFree;
    logic                  anyBusy;
    logic                  rHit;

    assign slotFree = !arValid || arReady;

    // Grant follows the pointer only when both caches contend.
    always_comb begin
        grantIc    = icReqValid && (!dcReqValid || rrPtr == MRRS_ICACHE);
        grantDc    = dcReqValid && (!icReqValid || rrPtr == MRRS_DCACHE);
        icReqReady = grantIc && slotFree && anyFree;
        dcReqReady = grantDc && slotFree && anyFree;
        accept     = icReqReady || dcReqReady;
        acceptSrc  = icReqReady ? MRRS_ICACHE : MRRS_DCACHE;
        acceptAddr = icReqReady ? icReqAddr : dcReqAddr;
    end

    memory_read_id_allocator #(
        .ID_WIDTH (ID_WIDTH)
    ) u_id_alloc (
        .clk         (clk),
        .rst         (rst),
        .allocValid  (accept),
        .allocOwner  (acceptSrc),
        .allocId     (allocId),
        .freeValid   (rValid && rLast),
        .freeId      (rId),
        .lookupId    (rId),
        .lookupBusy  (lookupBusy),
        .lookupOwner (lookupOwner),
        .anyFree     (anyFree),
        .anyBusy     (anyBusy)
    );

    // AR output register: reloads on accept (even while draining), clears when drained idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arValid <= 1'b0;
            arId    <= '0;
            arAddr  <= '0;
        end else if (accept) begin
            arValid <= 1'b1;
            arId    <= allocId;
            arAddr  <= acceptAddr;
        end else if (arReady) begin
            arValid <= 1'b0;
        end
    end

    // Pointer passes to the other cache only when a request is actually taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rrPtr <= MRRS_ICACHE;
        else if (accept) rrPtr <= other_source(acceptSrc);
    end

    // Sticky flag for beats arriving on an ID that nobody owns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       protocolError <= 1'b0;
        else if (rValid && !lookupBusy) protocolError <= 1'b1;
    end

    // Zero-latency R routing; beats on unallocated IDs are dropped.
    always_comb begin
        rHit        = rValid && lookupBusy;
        icRespValid = rHit && lookupOwner == MRRS_ICACHE;
        dcRespValid = rHit && lookupOwner == MRRS_DCACHE;
        icRespData  = rData;
        dcRespData  = rData;
        icRespLast  = rLast;
        dcRespLast  = rLast;
    end

    assign rReady = rst;
    assign busy   = arValid || anyBusy;

endmodule

// File: tb/tb_memory_read_arbiter.sv
module tb_memory_read_arbiter;

    localparam int IDW = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int NID = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           icReqValid, dcReqValid, icReqReady, dcReqReady;
    logic [AW-1:0]  icReqAddr, dcReqAddr, arAddr;
    logic           arValid, arReady;
    logic [IDW-1:0] arId, rId;
    logic           rValid, rReady, rLast;
    logic [DW-1:0]  rData, icRespData, dcRespData;
    logic           icRespValid, icRespLast, dcRespValid, dcRespLast;
    logic           busy, protocolError;

    int checks = 0;
    int errors = 0;

    // Reference model: ID table as plain arrays, AR slot, pointer (0 = I-cache), sticky error.
    bit            m_busy [NID];
    bit            m_own  [NID];
    bit            m_rr;
    bit            m_arv;
    int            m_arid;
    logic [AW-1:0] m_araddr;
    bit            m_err;

    memory_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .icReqValid(icReqValid), .icReqAddr(icReqAddr), .icReqReady(icReqReady),
        .dcReqValid(dcReqValid), .dcReqAddr(dcReqAddr), .dcReqReady(dcReqReady),
        .arValid(arValid), .arReady(arReady), .arId(arId), .arAddr(arAddr),
        .rValid(rValid), .rReady(rReady), .rId(rId), .rData(rData), .rLast(rLast),
        .icRespValid(icRespValid), .icRespData(icRespData), .icRespLast(icRespLast),
        .dcRespValid(dcRespValid), .dcRespData(dcRespData), .dcRespLast(dcRespLast),
        .busy(busy), .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NID; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit any_busy();
        for (int i = 0; i < NID; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NID; i++) begin
            m_busy[i] = 1'b0;
            m_own[i]  = 1'b0;
        end
        m_rr = 1'b0; m_arv = 1'b0; m_arid = 0; m_araddr = '0; m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        icReqValid = 1'b0; icReqAddr = '0;
        dcReqValid = 1'b0; dcReqAddr = '0;
        arReady = 1'b0;
        rValid = 1'b0; rId = '0; rData = '0; rLast = 1'b0;
    endtask

    // Asynchronous reset from wherever we are, checked before any clock edge.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("rst_arValid", arValid, 0);
        chk("rst_arId", arId, 0);
        chk("rst_arAddr", arAddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_protocolError", protocolError, 0);
        chk("rst_rReady", rReady, 0);
        chk("rst_icRespValid", icRespValid, 0);
        chk("rst_dcRespValid", dcRespValid, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: check combinational outputs, take the edge, advance the model, check registers.
    task automatic tick();
        bit slot, gic, gdc, eic, edc, hit;
        int low;
        #1;
        slot = !m_arv || arReady;
        low  = lowest_free();
        gic  = icReqValid && (!dcReqValid || m_rr == 1'b0);
        gdc  = dcReqValid && (!icReqValid || m_rr == 1'b1);
        eic  = gic && slot && (low >= 0);
        edc  = gdc && slot && (low >= 0);
        hit  = rValid && m_busy[rId];
        chk("icReqReady", icReqReady, eic);
        chk("dcReqReady", dcReqReady, edc);
        chk("icRespValid", icRespValid, hit && !m_own[rId]);
        chk("dcRespValid", dcRespValid, hit && m_own[rId]);
        chk("rReady", rReady, 1);
        if (hit && !m_own[rId]) begin
            chk("icRespData", icRespData, rData);
            chk("icRespLast", icRespLast, rLast);
        end
        if (hit && m_own[rId]) begin
            chk("dcRespData", dcRespData, rData);
            chk("dcRespLast", dcRespLast, rLast);
        end
        @(posedge clk);
        if (eic || edc) begin
            m_arv = 1'b1;
            m_arid = low;
            m_araddr = eic ? icReqAddr : dcReqAddr;
            m_busy[low] = 1'b1;
            m_own[low] = edc;
            m_rr = edc ? 1'b0 : 1'b1;
        end else if (arReady) begin
            m_arv = 1'b0;
        end
        if (rValid && !hit) m_err = 1'b1;
        if (hit && rLast) m_busy[rId] = 1'b0;
        #1;
        chk("arValid", arValid, m_arv);
        if (m_arv) begin
            chk("arId", arId, m_arid);
            chk("arAddr", arAddr, m_araddr);
        end
        chk("busy", busy, m_arv || any_busy());
        chk("protocolError", protocolError, m_err);
    endtask

    initial begin
        int q[$];
        idle_inputs();
        rst = 1'b0;
        #3;
        do_reset();

        // Single I-cache read, four-beat burst back.
        icReqValid = 1'b1; icReqAddr = 32'h1000; arReady = 1'b1;
        #1 chk("t1_icReqReady", icReqReady, 1);
        tick();
        chk("t1_arValid", arValid, 1);
        chk("t1_arId", arId, 0);
        chk("t1_arAddr", arAddr, 32'h1000);
        icReqValid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rValid = 1'b1; rId = 2'd0; rData = {$urandom, $urandom}; rLast = (b == 3);
            #1 chk("t1_icRespValid", icRespValid, 1);
            chk("t1_icRespLast", icRespLast, (b == 3));
            tick();
        end
        rValid = 1'b0; rLast = 1'b0;
        tick();
        chk("t1_busy_after", busy, 0);

        // Contention: strict alternation until IDs run out.
        do_reset();
        icReqValid = 1'b1; icReqAddr = 32'h100;
        dcReqValid = 1'b1; dcReqAddr = 32'h200;
        arReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_icReqReady", icReqReady, (k % 2 == 0));
            tick();
            chk("t2_arId", arId, k);
            chk("t2_arAddr", arAddr, (k % 2 == 0) ? 32'h100 : 32'h200);
        end
        #1 chk("t2_full_ic", icReqReady, 0);
        chk("t2_full_dc", dcReqReady, 0);
        tick();

        // Free ID 2: no accept in the freeing cycle, the next one reuses it.
        rValid = 1'b1; rId = 2'd2; rLast = 1'b1; rData = 64'hABCD;
        #1 chk("t3_same_cycle_ic", icReqReady, 0);
        chk("t3_same_cycle_dc", dcReqReady, 0);
        tick();
        rValid = 1'b0; rLast = 1'b0;
        tick();
        chk("t3_arId", arId, 2);
        chk("t3_arAddr", arAddr, 32'h100);

        // AR held by !arReady with a D-cache request pending.
        icReqValid = 1'b0; dcReqAddr = 32'h2000; arReady = 1'b0;
        rValid = 1'b1; rId = 2'd0; rLast = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_dcReqReady_held", dcReqReady, 0);
            tick();
            rValid = 1'b0; rLast = 1'b0;
            chk("t4_arId_stable", arId, 2);
            chk("t4_arAddr_stable", arAddr, 32'h100);
        end
        arReady = 1'b1;
        #1 chk("t4_dcReqReady_go", dcReqReady, 1);
        tick();
        chk("t4_arId", arId, 0);
        chk("t4_arAddr", arAddr, 32'h2000);

        // Beat on a free ID is dropped and latches the error.
        dcReqValid = 1'b0;
        rValid = 1'b1; rId = 2'd3; rLast = 1'b1;
        tick();
        rLast = 1'b0;
        #1 chk("t5_icRespValid", icRespValid, 0);
        chk("t5_dcRespValid", dcRespValid, 0);
        tick();
        chk("t5_err", protocolError, 1);
        rValid = 1'b0;
        tick();
        tick();
        chk("t5_err_sticky", protocolError, 1);

        // Reset with two IDs outstanding, then restart from ID 0.
        do_reset();
        icReqValid = 1'b1; icReqAddr = 32'h3000; arReady = 1'b1;
        tick();
        icReqValid = 1'b0; dcReqValid = 1'b1; dcReqAddr = 32'h4000;
        tick();
        #2;
        do_reset();
        icReqValid = 1'b1; icReqAddr = 32'h5000; arReady = 1'b1;
        tick();
        chk("t6_arId", arId, 0);
        icReqValid = 1'b0;
        rValid = 1'b1; rId = 2'd1; rLast = 1'b1;
        tick();
        chk("t6_old_id_err", protocolError, 1);
        rValid = 1'b0; rLast = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            icReqValid = ($urandom_range(0, 2) != 0);
            icReqAddr  = $urandom;
            dcReqValid = ($urandom_range(0, 2) != 0);
            dcReqAddr  = $urandom;
            arReady    = ($urandom_range(0, 3) != 0);
            rValid     = ($urandom_range(0, 1) != 0);
            rData      = {$urandom, $urandom};
            rLast      = ($urandom_range(0, 2) == 0);
            q.delete();
            for (int i = 0; i < NID; i++) if (m_busy[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 19) != 0)
                rId = IDW'(q[$urandom_range(0, q.size() - 1)]);
            else if (q.size() == 0 && $urandom_range(0, 19) != 0)
                rValid = 1'b0;
            else
                rId = IDW'($urandom_range(0, NID - 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
